// File: rtl/skid_pipeline_pkg.sv
// Shared types and sizing helpers for the skid_pipeline chain.
package skid_pipeline_pkg;

  // Per-stage occupancy state; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam int unsigned MAX_STAGES = 8;

  // Width needed to count 0..2*stages held entries.
  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/skid_pipeline_stage.sv
// One skid-buffer stage: main + skid register, registered in_ready.
// Optional macro SKID_PIPELINE_DATA_CLEAR_EN: data registers are reset and
// cleared by flush; otherwise they carry no reset and only state is cleared.
//
// state | meaning
// EMPTY | nothing held
// BUSY  | main holds the head entry
// FULL  | main holds the head, skid holds the next entry; input stalled
module skid_stage
  import skid_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  stage_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic                  acc, take;
  logic                  load_main_in, load_main_skid, load_skid;

  // Handshake outputs depend only on the state register (and flush), so
  // back-pressure never ripples combinationally through the chain.
  assign in_ready  = (state_q != FULL) & ~flush;
  assign out_valid = (state_q != EMPTY) & ~flush;
  assign out_data  = main_q;
  assign count     = state_q;

  assign acc  = in_valid & in_ready;
  assign take = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next state and data-register load enables.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d      = BUSY;
            load_main_in = 1'b1;
          end
        end
        BUSY: begin
          if (acc && !take) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (acc && take) begin
            load_main_in = 1'b1;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            state_d        = BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

`ifdef SKID_PIPELINE_DATA_CLEAR_EN
  // Data registers with reset and flush clear, so idle out_data reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end
`else
  // Data registers without reset; validity is carried by state alone.
  always_ff @(posedge clk) begin
    if (load_main_in)        main_q <= in_data;
    else if (load_main_skid) main_q <= skid_q;
    if (load_skid)           skid_q <= in_data;
  end
`endif

endmodule

// File: rtl/skid_pipeline.sv
// Chain of STAGES skid stages with synchronous flush and occupancy count.
// Optional macro SKID_PIPELINE_DATA_CLEAR_EN (applied inside skid_stage)
// zeroes the data registers on reset and flush.
module skid_pipeline
  import skid_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [occ_width(STAGES)-1:0]   occupancy
);

  localparam int OCC_W = occ_width(STAGES);

  // Index i is the input side of stage i; index STAGES is the chain output.
  logic [STAGES:0]       vld;
  logic [STAGES:0]       rdy;
  logic [DATA_WIDTH-1:0] dat [STAGES+1];
  logic [1:0]            cnt [STAGES];

  assign vld[0]      = in_valid;
  assign dat[0]      = in_data;
  assign in_ready    = rdy[0];
  assign out_valid   = vld[STAGES];
  assign out_data    = dat[STAGES];
  assign rdy[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    skid_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (vld[i]),
      .in_ready (rdy[i]),
      .in_data  (dat[i]),
      .out_valid(vld[i+1]),
      .out_ready(rdy[i+1]),
      .out_data (dat[i+1]),
      .count    (cnt[i])
    );
  end

  // Total entries held: sum of per-stage counts.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(cnt[i]);
    end
  end

endmodule
